// File: rtl/miinst_issue_queue_pkg.sv
// Shared micro-instruction types, group size and constructor for the issue queue.
package miinst_issue_queue_pkg;

  localparam int unsigned MQ_N  = 4;
  localparam int unsigned MQ_KW = $clog2(MQ_N + 1);
  localparam int unsigned MQ_IW = $clog2(MQ_N);

  typedef enum logic [3:0] {
    MIOP_NOP    = 4'd0,
    MIOP_ADDI   = 4'd1,
    MIOP_ADD    = 4'd2,
    MIOP_LOAD   = 4'd3,
    MIOP_STORE  = 4'd4,
    MIOP_BRANCH = 4'd5
  } miop_t;

  typedef enum logic [1:0] {
    BMD_8  = 2'd0,
    BMD_16 = 2'd1,
    BMD_32 = 2'd2
  } bmd_t;

  typedef struct packed {
    miop_t       op;
    logic [2:0]  rd;
    logic [2:0]  rs1;
    logic [2:0]  rs2;
    logic [15:0] imm;
    bmd_t        bmd;
    logic        lock;
  } miinst_t;

  function automatic miinst_t make_miinst(input miop_t op, input logic [2:0] rd,
                                          input logic [2:0] rs1, input logic [2:0] rs2,
                                          input logic [15:0] imm, input bmd_t bmd,
                                          input logic lock);
    miinst_t m;
    m.op   = op;
    m.rd   = rd;
    m.rs1  = rs1;
    m.rs2  = rs2;
    m.imm  = imm;
    m.bmd  = bmd;
    m.lock = lock;
    return m;
  endfunction

  localparam miinst_t MIINST_NOP = make_miinst(MIOP_NOP, 3'd0, 3'd0, 3'd0, 16'd0, BMD_32, 1'b0);

endpackage

// File: rtl/miinst_issue_queue_nop_compactor.sv
// Combinational group compactor. With MIINST_NOP_SKIP_EN defined, NOP entries
// are squeezed out and the survivors packed from index 0; otherwise pass-through.
module miinst_nop_compactor
  import miinst_issue_queue_pkg::*;
(
  input  miinst_t [MQ_N-1:0] in_miinst,
  output miinst_t [MQ_N-1:0] cmp_miinst_c,
  output logic [MQ_KW-1:0]   k_c
);

`ifdef MIINST_NOP_SKIP_EN
  // Pack non-NOP entries in arrival order and count them.
  always_comb begin
    logic [MQ_KW-1:0] cnt;
    cmp_miinst_c = {MQ_N{MIINST_NOP}};
    cnt          = '0;
    for (int i = 0; i < MQ_N; i++) begin
      if (in_miinst[i].op != MIOP_NOP) begin
        cmp_miinst_c[cnt[MQ_IW-1:0]] = in_miinst[i];
        cnt = cnt + MQ_KW'(1);
      end
    end
    k_c = cnt;
  end
`else
  assign cmp_miinst_c = in_miinst;
  assign k_c          = MQ_KW'(MQ_N);
`endif

endmodule

// File: rtl/miinst_issue_queue.sv
// Circular FIFO taking MQ_N micro-instructions per cycle from decode and issuing
// one per cycle under valid/ready. Optional feature macro: MIINST_NOP_SKIP_EN
// (drop NOP entries at enqueue).
module miinst_issue_queue
  import miinst_issue_queue_pkg::*;
#(
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     in_valid,
  input  miinst_t [MQ_N-1:0]       in_miinst,
  output logic                     in_ready,
  output logic                     out_valid,
  output miinst_t                  out_miinst,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  miinst_t            mem [DEPTH];
  logic [PW-1:0]      wr_ptr;
  logic [PW-1:0]      rd_ptr;
  miinst_t [MQ_N-1:0] cmp_miinst;
  logic [MQ_KW-1:0]   cmp_k;
  logic               enq;
  logic               deq;

  miinst_nop_compactor u_compactor (
    .in_miinst    (in_miinst),
    .cmp_miinst_c (cmp_miinst),
    .k_c          (cmp_k)
  );

  // Handshake flags depend only on stored occupancy.
  assign in_ready   = (count <= CW'(DEPTH - MQ_N));
  assign out_valid  = (count != '0);
  assign out_miinst = out_valid ? mem[rd_ptr] : MIINST_NOP;

  assign enq = in_valid && in_ready && !flush;
  assign deq = out_valid && out_ready && !flush;

  // Pointer and occupancy bookkeeping; flush wins over enqueue/dequeue.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (enq) wr_ptr <= wr_ptr + PW'(cmp_k);
      if (deq) rd_ptr <= rd_ptr + PW'(1);
      count <= count + (enq ? CW'(cmp_k) : CW'(0)) - (deq ? CW'(1) : CW'(0));
    end
  end

  // Storage write of the compacted group; contents need no reset.
  always_ff @(posedge clk) begin
    if (enq) begin
      for (int i = 0; i < MQ_N; i++) begin
        if (MQ_KW'(i) < cmp_k) mem[wr_ptr + PW'(i)] <= cmp_miinst[i];
      end
    end
  end

endmodule

// File: tb/tb_miinst_issue_queue.sv
// Scoreboard bench for miinst_issue_queue: expected entries are queued on accepted
// groups and compared in order as the queue issues them.
module tb_miinst_issue_queue;
  import miinst_issue_queue_pkg::*;

  localparam int unsigned DEPTH = 16;
  typedef miinst_t [MQ_N-1:0] grp_t;

  logic    clk = 1'b0;
  logic    reset = 1'b0;
  logic    flush = 1'b0;
  logic    in_valid = 1'b0;
  logic    out_ready = 1'b0;
  grp_t    in_miinst = '0;
  logic    in_ready;
  logic    out_valid;
  miinst_t out_miinst;
  logic [4:0] count;

  miinst_t exp_q[$];
  int      n_chk = 0;
  int      n_fail = 0;
  int      peak = 0;
  grp_t    g_idle = '0;

  always #5 clk = ~clk;

  miinst_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .in_valid   (in_valid),
    .in_miinst  (in_miinst),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_miinst (out_miinst),
    .out_ready  (out_ready),
    .count      (count)
  );

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic miinst_t rnd_inst(input bit nop_ok);
    miop_t op;
    if (nop_ok && ($urandom_range(0, 3) == 0)) op = MIOP_NOP;
    else op = miop_t'(4'($urandom_range(1, 5)));
    return make_miinst(op, 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                       3'($urandom_range(0, 7)), 16'($urandom), BMD_16, 1'($urandom_range(0, 1)));
  endfunction

  function automatic grp_t rnd_group(input bit nop_ok);
    grp_t g;
    for (int i = 0; i < MQ_N; i++) g[i] = rnd_inst(nop_ok);
    return g;
  endfunction

  // One clock cycle, entered just after a falling edge.
  task automatic cycle(input logic iv, input grp_t g, input logic ordy, input logic fl);
    int sz;
    in_valid  = iv;
    in_miinst = g;
    out_ready = ordy;
    flush     = fl;
    #1;
    sz = exp_q.size();
    check_val("out_valid", out_valid, sz != 0);
    check_val("in_ready", in_ready, sz <= DEPTH - MQ_N);
    if (sz != 0) begin
      check_val("out_miinst", out_miinst, exp_q[0]);
      if (ordy && !fl) void'(exp_q.pop_front());
    end else begin
      check_val("out_nop", out_miinst, MIINST_NOP);
    end
    if (iv && (sz <= DEPTH - MQ_N) && !fl) begin
      for (int i = 0; i < MQ_N; i++) begin
`ifdef MIINST_NOP_SKIP_EN
        if (g[i].op != MIOP_NOP) exp_q.push_back(g[i]);
`else
        exp_q.push_back(g[i]);
`endif
      end
    end
    if (fl) exp_q.delete();
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    check_val("count", count, exp_q.size());
    if (int'(count) > peak) peak = int'(count);
  endtask

  task automatic drain(input int budget);
    for (int i = 0; i < budget && exp_q.size() > 0; i++) cycle(1'b0, g_idle, 1'b1, 1'b0);
    check_val("drained", count, 0);
  endtask

  initial begin
    grp_t g;
    int   exp_peak;

    #1 reset = 1'b1;
    #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_in_ready", in_ready, 1);
    check_val("rst_count", count, 0);
    check_val("rst_out_nop", out_miinst, MIINST_NOP);
    @(negedge clk);
    reset = 1'b0;

    // Single group: ADDI, STORE, NOP, NOP
    g[0] = make_miinst(MIOP_ADDI, 3'd1, 3'd2, 3'd0, 16'h0010, BMD_32, 1'b0);
    g[1] = make_miinst(MIOP_STORE, 3'd0, 3'd3, 3'd1, 16'h0004, BMD_32, 1'b0);
    g[2] = MIINST_NOP;
    g[3] = MIINST_NOP;
    peak = 0;
    cycle(1'b1, g, 1'b1, 1'b0);
    for (int i = 0; i < 5; i++) cycle(1'b0, g_idle, 1'b1, 1'b0);
`ifdef MIINST_NOP_SKIP_EN
    exp_peak = 2;
`else
    exp_peak = 4;
`endif
    check_val("single_peak", peak, exp_peak);
    check_val("single_end", count, 0);

    // Fill with out_ready low until in_ready drops, then one rejected group
    for (int i = 0; i < 4; i++) cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    check_val("fill_count", count, 16);
    check_val("fill_in_ready", in_ready, 0);
    cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    check_val("fill_hold", count, 16);
    drain(20);

    // Simultaneous enqueue and dequeue from count 5
    cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, g_idle, 1'b1, 1'b0);
    check_val("simul_pre", count, 5);
    cycle(1'b1, rnd_group(1'b0), 1'b1, 1'b0);
    check_val("simul_post", count, 8);
    drain(12);

    // Flush with a group presented in the same cycle at count 7
    cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    cycle(1'b0, g_idle, 1'b1, 1'b0);
    check_val("flush_pre", count, 7);
    cycle(1'b1, rnd_group(1'b0), 1'b1, 1'b1);
    check_val("flush_count", count, 0);
    check_val("flush_out_valid", out_valid, 0);
    cycle(1'b0, g_idle, 1'b1, 1'b0);
    cycle(1'b1, rnd_group(1'b0), 1'b1, 1'b0);
    drain(8);

    // Random traffic across pointer wrap
    for (int i = 0; i < 60; i++)
      cycle(1'($urandom_range(0, 9) < 7), rnd_group(1'b1), 1'($urandom_range(0, 9) < 7), 1'b0);
    drain(40);

    // Asynchronous reset mid-cycle at count 9 with a group in flight
    for (int i = 0; i < 3; i++) cycle(1'b1, rnd_group(1'b0), 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) cycle(1'b0, g_idle, 1'b1, 1'b0);
    check_val("areset_pre", count, 9);
    in_valid  = 1'b1;
    in_miinst = rnd_group(1'b0);
    out_ready = 1'b1;
    #2 reset = 1'b1;
    #1;
    check_val("areset_out_valid", out_valid, 0);
    check_val("areset_in_ready", in_ready, 1);
    check_val("areset_count", count, 0);
    exp_q.delete();
    @(negedge clk);
    reset    = 1'b0;
    in_valid = 1'b0;
    cycle(1'b0, g_idle, 1'b1, 1'b0);
    cycle(1'b1, rnd_group(1'b0), 1'b1, 1'b0);
    drain(8);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
